// File: rtl/chenillard_pkg.sv
// Shared types and constants for the LED chase Avalon-MM initiator.
package chenillard_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        WAIT  = 2'd3
    } state_e;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    localparam int         LED_W         = 8;
    localparam logic [7:0] PATTERN_RESET = 8'h01;

endpackage

// File: rtl/chenillard_avm_master_if.sv
// Avalon-MM signal bundle between the chase initiator and the PIO s1 port.
interface chenillard_avm_master_if;

    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata, avm_waitrequest
    );

endinterface

// File: rtl/chenillard_tick_gen.sv
// Step-interval counter: cleared on entry to WAIT, pulses done on the last WAIT cycle.
module chenillard_tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic run_i,
    output logic done_o
);

    localparam int            CW = $clog2(TICK_DIV) + 1;
    localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Holds at the terminal count so a long WAIT can never wrap the counter.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != TC)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = run_i && (cnt_q == TC);

endmodule

// File: rtl/chenillard_avm_master.sv
// Running-light Avalon-MM initiator: write pattern to the PIO, read it back, wait, rotate.
// IDLE: bus idle, waiting for enable | WRITE: pattern write | READ: readback check | WAIT: step interval
module chenillard_avm_master #(
    parameter int         TICK_DIV = 5000000,
    parameter int         LED_W    = chenillard_pkg::LED_W,
    parameter logic [1:0] PIO_ADDR = chenillard_pkg::PIO_DATA_ADDR
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable_i,
    input  logic                    dir_i,
    input  logic                    clear_err_i,
    chenillard_avm_master_if.master avm,
    output logic [LED_W-1:0]        pattern_o,
    output logic                    busy_o,
    output logic                    err_o,
    output logic [7:0]              err_count_o
);

    import chenillard_pkg::*;

    state_e           state_q, state_d;
    logic [LED_W-1:0] pattern_q, pattern_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             tick_clr, tick_run, tick_done;

    chenillard_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (tick_clr),
        .run_i   (tick_run),
        .done_o  (tick_done)
    );

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        tick_clr  = 1'b0;
        tick_run  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) state_d = WRITE;
            end
            WRITE: begin
                if (!avm.avm_waitrequest) state_d = READ;
            end
            READ: begin
                if (!avm.avm_waitrequest) begin
                    state_d  = WAIT;
                    tick_clr = 1'b1;
                    if (avm.avm_readdata != 32'(pattern_q)) begin
                        err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            WAIT: begin
                tick_run = 1'b1;
                if (tick_done) begin
                    pattern_d = dir_i ? {pattern_q[0], pattern_q[LED_W-1:1]}
                                      : {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
                    state_d   = enable_i ? WRITE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Clearing wins over a mismatch seen in the same cycle.
        if (clear_err_i) begin
            err_d     = 1'b0;
            err_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pattern_q <= LED_W'(PATTERN_RESET);
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        avm.avm_address    = PIO_ADDR;
        avm.avm_chipselect = (state_q == WRITE) || (state_q == READ);
        avm.avm_write_n    = (state_q != WRITE);
        avm.avm_writedata  = (state_q == WRITE) ? 32'(pattern_q) : 32'd0;
    end

    assign pattern_o   = pattern_q;
    assign busy_o      = (state_q == WRITE) || (state_q == READ);
    assign err_o       = err_q;
    assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_chenillard_avm_master.sv
// Self-checking bench: PIO slave model plus a step-level reference of pattern and error state.
module tb_chenillard_avm_master;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable, dir, clear_err;
    logic [7:0] pattern;
    logic       busy, err;
    logic [7:0] err_count;

    chenillard_avm_master_if bus();

    chenillard_avm_master #(.TICK_DIV(TICK_DIV), .LED_W(8), .PIO_ADDR(2'd0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable_i    (enable),
        .dir_i       (dir),
        .clear_err_i (clear_err),
        .avm         (bus.master),
        .pattern_o   (pattern),
        .busy_o      (busy),
        .err_o       (err),
        .err_count_o (err_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_pat;
    logic        err_m;
    int          cnt_m;
    logic [31:0] pio_reg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] next_pat(input logic [7:0] p, input bit right);
        if (!right) return (p == 8'h80) ? 8'h01 : 8'(p * 2);
        return (p == 8'h01) ? 8'h80 : 8'(p / 2);
    endfunction

    // Entered in WRITE; leaves after the step advance (WRITE if en_after, else IDLE).
    // bad: 0 good readback, 1 = 0x11, 2 = upper bit set, 3 = low byte inverted.
    task automatic do_step(input int stall, input int bad, input bit clr,
                           input bit dir_v, input bit en_after);
        logic [31:0] wd;
        chk("wr_cs", 32'(bus.avm_chipselect), 32'd1);
        chk("wr_wn", 32'(bus.avm_write_n), 32'd0);
        chk("wr_data", bus.avm_writedata, {24'd0, exp_pat});
        chk("wr_addr", 32'(bus.avm_address), 32'd0);
        chk("wr_busy", 32'(busy), 32'd1);
        wd = bus.avm_writedata;
        for (int i = 0; i < stall; i++) begin
            bus.avm_waitrequest = 1'b1;
            tick();
            chk("stall_cs", 32'(bus.avm_chipselect), 32'd1);
            chk("stall_wn", 32'(bus.avm_write_n), 32'd0);
            chk("stall_data", bus.avm_writedata, wd);
        end
        bus.avm_waitrequest = 1'b0;
        pio_reg = bus.avm_writedata;
        tick();
        chk("rd_cs", 32'(bus.avm_chipselect), 32'd1);
        chk("rd_wn", 32'(bus.avm_write_n), 32'd1);
        chk("rd_busy", 32'(busy), 32'd1);
        case (bad)
            1:       bus.avm_readdata = 32'h0000_0011;
            2:       bus.avm_readdata = pio_reg | 32'h8000_0000;
            3:       bus.avm_readdata = pio_reg ^ 32'h0000_00FF;
            default: bus.avm_readdata = pio_reg;
        endcase
        enable    = en_after;
        clear_err = clr;
        if (clr) begin
            err_m = 1'b0;
            cnt_m = 0;
        end else if (bad != 0) begin
            err_m = 1'b1;
            if (cnt_m < 255) cnt_m++;
        end
        tick();
        clear_err = 1'b0;
        bus.avm_readdata = pio_reg;
        chk("wait_cs", 32'(bus.avm_chipselect), 32'd0);
        chk("wait_busy", 32'(busy), 32'd0);
        chk("err", 32'(err), 32'(err_m));
        chk("err_count", 32'(err_count), 32'(cnt_m));
        for (int i = 0; i < TICK_DIV - 1; i++) begin
            dir = 1'($urandom_range(0, 1));
            tick();
            chk("wait_cs_hold", 32'(bus.avm_chipselect), 32'd0);
            chk("wait_pat", 32'(pattern), 32'(exp_pat));
        end
        dir = dir_v;
        tick();
        exp_pat = next_pat(exp_pat, dir_v);
        chk("adv_pat", 32'(pattern), 32'(exp_pat));
        chk("adv_cs", 32'(bus.avm_chipselect), en_after ? 32'd1 : 32'd0);
        chk("adv_wn", 32'(bus.avm_write_n), en_after ? 32'd0 : 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 1'b0;
        dir = 1'b0;
        clear_err = 1'b0;
        bus.avm_readdata = 32'd0;
        bus.avm_waitrequest = 1'b0;
        pio_reg = 32'd0;
        exp_pat = 8'h01;
        err_m = 1'b0;
        cnt_m = 0;
        repeat (3) tick();
        chk("rst_cs", 32'(bus.avm_chipselect), 32'd0);
        chk("rst_wn", 32'(bus.avm_write_n), 32'd1);
        chk("rst_wdata", bus.avm_writedata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pat", 32'(pattern), 32'h01);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(err_count), 32'd0);
        reset_n = 1'b1;
        repeat (3) begin
            tick();
            chk("idle_cs", 32'(bus.avm_chipselect), 32'd0);
        end
        enable = 1'b1;
        tick();

        // Left chase through a full wrap, then reverse after 0x04.
        for (int i = 0; i < 10; i++) do_step(0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) do_step(0, 0, 0, 1'b1, 1'b1);
        do_step(3, 0, 0, 1'b0, 1'b1);

        do_step(0, 1, 0, 1'b0, 1'b1);
        chk("first_err", 32'(err), 32'd1);
        chk("first_cnt", 32'(err_count), 32'd1);
        for (int i = 0; i < 300; i++) do_step(0, int'($urandom_range(1, 3)), 0, 1'b0, 1'b1);
        chk("sat_cnt", 32'(err_count), 32'd255);
        do_step(0, 0, 1, 1'b0, 1'b1);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_cnt", 32'(err_count), 32'd0);
        do_step(0, 2, 1, 1'b0, 1'b1);
        chk("clr_prio_cnt", 32'(err_count), 32'd0);
        do_step(0, 1, 0, 1'b0, 1'b1);
        chk("recount", 32'(err_count), 32'd1);

        for (int i = 0; i < 40; i++) begin
            do_step(int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                    ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'b1);
        end

        // Drop enable during the READ of 0x08.
        for (int k = 0; k < 16 && exp_pat != 8'h08; k++) do_step(0, 0, 0, 1'b0, 1'b1);
        do_step(0, 0, 0, 1'b0, 1'b0);
        chk("drop_pat", 32'(pattern), 32'h10);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stop_cs", 32'(bus.avm_chipselect), 32'd0);
        end
        enable = 1'b1;
        tick();
        do_step(0, 3, 0, 1'b0, 1'b1);

        // Reset in WRITE.
        reset_n = 1'b0;
        tick();
        exp_pat = 8'h01;
        err_m = 1'b0;
        cnt_m = 0;
        chk("mid_rst_cs", 32'(bus.avm_chipselect), 32'd0);
        chk("mid_rst_pat", 32'(pattern), 32'h01);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_cnt", 32'(err_count), 32'd0);
        reset_n = 1'b1;
        tick();
        do_step(0, 0, 0, 1'b0, 1'b1);
        do_step(0, 0, 0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
